// File: rtl/toggle_event_decoder_pkg.sv
// Shared types and default sizing for the toggle-encoded event receiver.
package toggle_event_decoder_pkg;

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        EMPTY = 2'd1,
        HOLD  = 2'd2,
        FULL  = 2'd3
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_PEND_W      = 3;
    localparam int unsigned SYNC_MIN        = 1;
    localparam int unsigned SYNC_MAX        = 4;

endpackage

// File: rtl/toggle_event_decoder_sync.sv
// Synchronizer chain plus previous-level register for any toggle-encoded line.
module toggle_sync
    import toggle_event_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic t_in,
    output logic det,
    output logic level
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain[0] <= t_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign det   = chain[SYNC_STAGES-1] ^ prev;
    assign level = prev;

endmodule

// File: rtl/toggle_event_decoder.sv
// Toggle-line event receiver: pending queue with valid/ready, event counter,
// sticky overrun and transmitter Q/Q' mirror.
module toggle_event_decoder
    import toggle_event_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned PEND_W      = DEF_PEND_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              T_IN,
    output logic              EVT_VALID,
    input  logic              EVT_READY,
    output logic [PEND_W-1:0] PENDING,
    output logic [CNT_W-1:0]  EVT_COUNT,
    output logic              OVERRUN,
    input  logic              CLR_OVR,
    output logic              Q_MIRROR,
    output logic              Q_PRIME_MIRROR
);

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("toggle_event_decoder: SYNC_STAGES out of range 1..4");
    end

    localparam logic [PEND_W-1:0] MAX_PEND = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]        ARM_LAST = 3'(SYNC_STAGES);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        arm_cnt;
    logic              det_raw;
    logic              det;
    logic              acc;
    logic              level;
    logic [PEND_W-1:0] pend_nxt;
    logic              ovr_set;

    toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (CLK),
        .rst_n(RST_N),
        .t_in (T_IN),
        .det  (det_raw),
        .level(level)
    );

    assign det = det_raw & (state != ARM);
    assign acc = EVT_VALID & EVT_READY;

    always_comb begin
        pend_nxt = PENDING;
        ovr_set  = 1'b0;
        if (det && !acc) begin
            if (PENDING == MAX_PEND) ovr_set  = 1'b1;
            else                     pend_nxt = PENDING + PEND_ONE;
        end else if (!det && acc) begin
            pend_nxt = PENDING - PEND_ONE;
        end

        if (pend_nxt == '0)            state_nxt = EMPTY;
        else if (pend_nxt == MAX_PEND) state_nxt = FULL;
        else                           state_nxt = HOLD;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= ARM;
            arm_cnt   <= '0;
            PENDING   <= '0;
            EVT_VALID <= 1'b0;
            EVT_COUNT <= '0;
            OVERRUN   <= 1'b0;
        end else if (state == ARM) begin
            // Hold off detection until prev has caught up with the synchronized level.
            arm_cnt <= arm_cnt + 3'd1;
            if (arm_cnt == ARM_LAST) state <= EMPTY;
        end else begin
            state     <= state_nxt;
            PENDING   <= pend_nxt;
            EVT_VALID <= (pend_nxt != '0);
            if (det) EVT_COUNT <= EVT_COUNT + CNT_ONE;
            if (ovr_set)      OVERRUN <= 1'b1;
            else if (CLR_OVR) OVERRUN <= 1'b0;
        end
    end

    assign Q_MIRROR       = level;
    assign Q_PRIME_MIRROR = ~level;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder with default parameters (2, 8, 3).
module tb_toggle_event_decoder;
    import toggle_event_decoder_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       T_IN;
    logic       EVT_VALID;
    logic       EVT_READY;
    logic [2:0] PENDING;
    logic [7:0] EVT_COUNT;
    logic       OVERRUN;
    logic       CLR_OVR;
    logic       Q_MIRROR;
    logic       Q_PRIME_MIRROR;

    int n_cmp = 0;
    int n_err = 0;
    int run;
    int max_run;
    int vcount;

    toggle_event_decoder #(
        .SYNC_STAGES(2),
        .CNT_W      (8),
        .PEND_W     (3)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .T_IN          (T_IN),
        .EVT_VALID     (EVT_VALID),
        .EVT_READY     (EVT_READY),
        .PENDING       (PENDING),
        .EVT_COUNT     (EVT_COUNT),
        .OVERRUN       (OVERRUN),
        .CLR_OVR       (CLR_OVR),
        .Q_MIRROR      (Q_MIRROR),
        .Q_PRIME_MIRROR(Q_PRIME_MIRROR)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST_N = 1'b0; T_IN = 1'b1; EVT_READY = 1'b0; CLR_OVR = 1'b0;

        // Reset with T_IN high, then release: no spurious event.
        step(3);
        chk("rst_pending", 32'(PENDING), 0);
        chk("rst_valid", 32'(EVT_VALID), 0);
        chk("rst_count", 32'(EVT_COUNT), 0);
        chk("rst_ovr", 32'(OVERRUN), 0);
        chk("rst_q", 32'(Q_MIRROR), 0);
        chk("rst_qp", 32'(Q_PRIME_MIRROR), 1);
        chk("rst_state", 32'(dut.state), 32'(ARM));
        RST_N = 1'b1;
        step(10);
        chk("arm_valid", 32'(EVT_VALID), 0);
        chk("arm_count", 32'(EVT_COUNT), 0);
        chk("arm_q", 32'(Q_MIRROR), 1);
        chk("arm_qp", 32'(Q_PRIME_MIRROR), 0);
        chk("arm_state", 32'(dut.state), 32'(EMPTY));

        // Single toggle: visible three edges later.
        T_IN = 1'b0;
        step(2);
        chk("lat_early", 32'(PENDING), 0);
        step(1);
        chk("one_pending", 32'(PENDING), 1);
        chk("one_valid", 32'(EVT_VALID), 1);
        chk("one_count", 32'(EVT_COUNT), 1);
        chk("one_state", 32'(dut.state), 32'(HOLD));
        EVT_READY = 1'b1;
        step(1);
        EVT_READY = 1'b0;
        chk("pop_pending", 32'(PENDING), 0);
        chk("pop_valid", 32'(EVT_VALID), 0);
        chk("pop_q", 32'(Q_MIRROR), 0);

        // Nine toggles with no consumer: saturate and overrun.
        for (int k = 0; k < 9; k++) begin
            T_IN = ~T_IN;
            step(3);
        end
        chk("sat_pending", 32'(PENDING), 7);
        chk("sat_ovr", 32'(OVERRUN), 1);
        chk("sat_count", 32'(EVT_COUNT), 10);
        chk("sat_state", 32'(dut.state), 32'(FULL));
        chk("sat_q", 32'(Q_MIRROR), 1);
        CLR_OVR = 1'b1;
        step(1);
        CLR_OVR = 1'b0;
        chk("clr_ovr", 32'(OVERRUN), 0);
        chk("clr_pending", 32'(PENDING), 7);

        // Toggle coinciding with an accept while FULL.
        T_IN = ~T_IN;
        step(2);
        EVT_READY = 1'b1;
        step(1);
        EVT_READY = 1'b0;
        chk("full_acc_pending", 32'(PENDING), 7);
        chk("full_acc_ovr", 32'(OVERRUN), 0);
        chk("full_acc_count", 32'(EVT_COUNT), 11);

        // Drain.
        EVT_READY = 1'b1;
        step(3);
        chk("drain_mid", 32'(PENDING), 4);
        step(4);
        chk("drain_pending", 32'(PENDING), 0);
        chk("drain_valid", 32'(EVT_VALID), 0);

        // 256 toggles with continuous ready: counter wraps, valid pulses once each.
        run = 0; max_run = 0; vcount = 0;
        for (int k = 0; k < 256; k++) begin
            T_IN = ~T_IN;
            for (int j = 0; j < 3; j++) begin
                step(1);
                if (EVT_VALID) begin
                    run++;
                    vcount++;
                    if (run > max_run) max_run = run;
                end else begin
                    run = 0;
                end
            end
            if (k == 244) chk("wrap_zero", 32'(EVT_COUNT), 0);
        end
        step(1);
        if (EVT_VALID) vcount++;
        chk("wrap_count", 32'(EVT_COUNT), 11);
        chk("wrap_ovr", 32'(OVERRUN), 0);
        chk("wrap_maxrun", 32'(max_run), 1);
        chk("wrap_vcount", 32'(vcount), 256);
        chk("wrap_pending", 32'(PENDING), 0);

        // Build PENDING=4 with OVERRUN=1, then reset mid-operation.
        EVT_READY = 1'b0;
        for (int k = 0; k < 8; k++) begin
            T_IN = ~T_IN;
            step(3);
        end
        step(1);
        chk("pre_count", 32'(EVT_COUNT), 19);
        EVT_READY = 1'b1;
        step(3);
        EVT_READY = 1'b0;
        chk("pre_pending", 32'(PENDING), 4);
        chk("pre_ovr", 32'(OVERRUN), 1);
        RST_N = 1'b0;
        T_IN  = 1'b1;
        step(1);
        RST_N = 1'b1;
        chk("mid_pending", 32'(PENDING), 0);
        chk("mid_ovr", 32'(OVERRUN), 0);
        chk("mid_valid", 32'(EVT_VALID), 0);
        chk("mid_count", 32'(EVT_COUNT), 0);
        chk("mid_state", 32'(dut.state), 32'(ARM));
        step(2);
        chk("rearm_state", 32'(dut.state), 32'(ARM));
        step(1);
        chk("rearm_exit", 32'(dut.state), 32'(EMPTY));
        step(5);
        chk("rearm_count", 32'(EVT_COUNT), 0);
        chk("rearm_valid", 32'(EVT_VALID), 0);
        chk("rearm_q", 32'(Q_MIRROR), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
